// File: rtl/cla_adder_if.sv
// cla_adder_if
// Operand/result bundle for cla_adder. Clock and reset stay outside as plain
// ports on the adder.
//   iX, iY     32-bit addends (master -> slave)
//   iCarry     carry-in at bit 0 (master -> slave)
//   oS         registered sum (slave -> master)
//   oCarry     registered unsigned carry-out of bit 31
//   oOverflow  registered two's-complement overflow
//   oZero      registered sum-is-zero flag (0 while in reset)
//   oNegative  registered copy of sum bit 31
interface cla_adder_if;
  logic [31:0] iX;
  logic [31:0] iY;
  logic        iCarry;
  logic [31:0] oS;
  logic        oCarry;
  logic        oOverflow;
  logic        oZero;
  logic        oNegative;

  modport master (
    output iX, iY, iCarry,
    input  oS, oCarry, oOverflow, oZero, oNegative
  );

  modport slave (
    input  iX, iY, iCarry,
    output oS, oCarry, oOverflow, oZero, oNegative
  );
endinterface

// File: rtl/cla_adder.sv
// cla_adder
// 32-bit two-level carry-lookahead adder with registered sum and ALU flags.
// Level 1: eight 4-bit groups with explicit internal carry equations plus
// group generate/propagate. Level 2: lookahead over the eight (G,P) pairs for
// c4..c32. Result and flags register together every rising edge, no enable.
//
// Ports:
//   iClk  clock, rising edge
//   nRst  asynchronous active-low reset; clears every register
//   bus   cla_adder_if.slave: iX, iY, iCarry in; oS, oCarry, oOverflow,
//         oZero, oNegative out
//
// Build option:
//   CLA_INPUT_REG_EN  when defined, iX/iY/iCarry are registered before the
//                     lookahead logic (latency 2 instead of 1).
module cla_adder (
  input  logic        iClk,
  input  logic        nRst,
  cla_adder_if.slave  bus
);

  // Operands seen by the lookahead logic.
  logic [31:0] w_x;
  logic [31:0] w_y;
  logic        w_cin;

`ifdef CLA_INPUT_REG_EN
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic        r_cin;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_cin <= 1'b0;
    end else begin
      r_x   <= bus.iX;
      r_y   <= bus.iY;
      r_cin <= bus.iCarry;
    end
  end

  assign w_x   = r_x;
  assign w_y   = r_y;
  assign w_cin = r_cin;
`else
  assign w_x   = bus.iX;
  assign w_y   = bus.iY;
  assign w_cin = bus.iCarry;
`endif

  // Bit-level generate / propagate.
  logic [31:0] w_g;
  logic [31:0] w_p;

  assign w_g = w_x & w_y;
  assign w_p = w_x ^ w_y;

  // Group generate/propagate and group carry-ins (w_gc[k] = c[4k]).
  logic [7:0] w_grp_g;
  logic [7:0] w_grp_p;
  logic [8:0] w_gc;

  // All bit carries c0..c32.
  logic [32:0] w_c;

  // Level-2 lookahead: carry out of group k expressed as a sum of products of
  // group G/P terms and c0, so no group waits on a neighbour's carry.
  function automatic logic f_lookahead(
    input logic [7:0]  g,
    input logic [7:0]  p,
    input logic        cin,
    input int unsigned k
  );
    logic acc;
    logic term;
    acc = 1'b0;
    for (int unsigned j = 0; j <= k; j++) begin
      term = g[j];
      for (int unsigned m = j + 1; m <= k; m++) begin
        term = term & p[m];
      end
      acc = acc | term;
    end
    term = cin;
    for (int unsigned m = 0; m <= k; m++) begin
      term = term & p[m];
    end
    return acc | term;
  endfunction

  assign w_gc[0] = w_cin;

  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_grp
      logic [3:0] w_gg;
      logic [3:0] w_pp;
      logic       w_ci;

      assign w_gg = w_g[4*k +: 4];
      assign w_pp = w_p[4*k +: 4];
      assign w_ci = w_gc[k];

      // Level 1: internal carries as flat lookahead equations.
      assign w_c[4*k]     = w_ci;
      assign w_c[4*k + 1] = w_gg[0]
                          | (w_pp[0] & w_ci);
      assign w_c[4*k + 2] = w_gg[1]
                          | (w_pp[1] & w_gg[0])
                          | (w_pp[1] & w_pp[0] & w_ci);
      assign w_c[4*k + 3] = w_gg[2]
                          | (w_pp[2] & w_gg[1])
                          | (w_pp[2] & w_pp[1] & w_gg[0])
                          | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);

      assign w_grp_g[k] = w_gg[3]
                        | (w_pp[3] & w_gg[2])
                        | (w_pp[3] & w_pp[2] & w_gg[1])
                        | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);
      assign w_grp_p[k] = &w_pp;

      // Level 2 carry into the next group.
      assign w_gc[k + 1] = f_lookahead(w_grp_g, w_grp_p, w_cin, k);
    end
  endgenerate

  assign w_c[32] = w_gc[8];

  // Sum and flags, all from the same combinational result.
  logic [31:0] w_s;
  logic        w_carry;
  logic        w_ovf;
  logic        w_zero;
  logic        w_neg;

  assign w_s     = w_p ^ w_c[31:0];
  assign w_carry = w_c[32];
  assign w_ovf   = w_c[31] ^ w_c[32];
  assign w_zero  = (w_s == '0);
  assign w_neg   = w_s[31];

  // Output registers. oZero clears to 0 so reset reads as "no result yet".
  logic [31:0] r_s;
  logic        r_carry;
  logic        r_ovf;
  logic        r_zero;
  logic        r_neg;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_s     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_s     <= w_s;
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
      r_zero  <= w_zero;
      r_neg   <= w_neg;
    end
  end

  assign bus.oS        = r_s;
  assign bus.oCarry    = r_carry;
  assign bus.oOverflow = r_ovf;
  assign bus.oZero     = r_zero;
  assign bus.oNegative = r_neg;

endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder
// Directed vector table plus reset and random sequences for cla_adder.
module tb_cla_adder;

`ifdef CLA_INPUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk;
  logic rst_n;

  cla_adder_if bus ();

  cla_adder u_dut (
    .iClk (clk),
    .nRst (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  localparam int unsigned NVEC = 14;
  vec_t vecs [NVEC];

  int unsigned n_cmp;
  int unsigned n_fail;

  // Packed result layout: {s[31:0], carry, overflow, zero, negative}
  function automatic logic [35:0] actual();
    return {bus.oS, bus.oCarry, bus.oOverflow, bus.oZero, bus.oNegative};
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got s=%h c=%b v=%b z=%b n=%b, expected s=%h c=%b v=%b z=%b n=%b",
               name, act[35:4], act[3], act[2], act[1], act[0],
               exp[35:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic cin);
    bus.iX     = x;
    bus.iY     = y;
    bus.iCarry = cin;
  endtask

  // Independent behavioural reference.
  function automatic logic [35:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic cin);
    logic [32:0] full;
    logic        v;
    full = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    v    = (x[31] == y[31]) && (full[31] != x[31]);
    return {full[31:0], full[32], v, (full[31:0] == 32'd0), full[31]};
  endfunction

  logic [35:0] q_exp [$];

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //          x             y             cin   s             c     v     z     n
    vecs[0]  = '{32'd5,        32'd10,       1'b0, 32'd15,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'd1,        32'd7,        1'b0, 32'd8,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'd400,      32'd33,       1'b0, 32'd433,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive(32'd0, 32'd0, 1'b0);
    #3;
    chk("reset_state", actual(), 36'd0);

    // Release between edges; first vector already on the inputs.
    drive(vecs[0].x, vecs[0].y, vecs[0].cin);
    #9;
    rst_n = 1'b1;

    // Back-to-back vectors, each checked exactly LAT edges after it is driven.
    for (int unsigned i = 0; i < NVEC + LAT - 1; i++) begin
      if (i < NVEC) drive(vecs[i].x, vecs[i].y, vecs[i].cin);
      step();
      if (i >= LAT - 1) begin
        chk($sformatf("vec%0d", i - (LAT - 1)), actual(),
            {vecs[i-(LAT-1)].s, vecs[i-(LAT-1)].c, vecs[i-(LAT-1)].v,
             vecs[i-(LAT-1)].z, vecs[i-(LAT-1)].n});
      end
    end

    // Reset mid-stream.
    drive(32'd400, 32'd33, 1'b0);
    repeat (LAT) step();
    chk("pre_reset", actual(), {32'd433, 4'b0000});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", actual(), 36'd0);
    step();
    chk("rst_hold", actual(), 36'd0);
    #3;
    rst_n = 1'b1;
    repeat (LAT) step();
    chk("rst_release", actual(), {32'd433, 4'b0000});

    // Random: 24-bit operands first, then full width, one op per cycle.
    q_exp.delete();
    for (int unsigned i = 0; i < 10000; i++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      logic        rc;
      rx = $urandom;
      ry = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i < 5000) begin
        rx = rx & 32'h00FFFFFF;
        ry = ry & 32'h00FFFFFF;
      end
      drive(rx, ry, rc);
      q_exp.push_back(ref_model(rx, ry, rc));
      step();
      if (q_exp.size() == LAT) begin
        chk($sformatf("rand%0d", i), actual(), q_exp.pop_front());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_adder.md
# cla_adder

32-bit carry-lookahead adder with a registered result and ALU status flags. It is the adder for the processor datapath's ALU: ADD/SUB-style operations and address arithmetic feed it. It computes X + Y + carry-in through a two-level lookahead tree of 4-bit groups, without ripple carry. The sum and the carry, overflow, zero and negative flags are captured in output registers.

## Interface
- No parameters. Width is fixed at 32 bits.
- iClk  in  1  clock; all state updates on the rising edge.
- nRst  in  1  reset. Asynchronous, active-low; clears all registers immediately.
- iX  in  32  addend X.
- iY  in  32  addend Y.
- iCarry  in  1  carry-in, added at bit 0.
- oS  out  32  registered sum, (iX + iY + iCarry) mod 2^32.
- oCarry  out  1  registered unsigned carry-out of bit 31.
- oOverflow  out  1  registered two's-complement overflow.
- oZero  out  1  registered flag, 1 when the sum is all zeros.
- oNegative  out  1  registered flag equal to sum bit 31.

## Operation
- Bit level:
  - g[i] = iX[i] & iY[i]
  - p[i] = iX[i] ^ iY[i]
- Level 1 (eight 4-bit groups):
  - Each group produces its internal carries, group generate G and group propagate P.
  - Carries are explicit lookahead equations, not a ripple chain.
- Level 2:
  - A lookahead unit over the eight (G, P) pairs produces the group carry-ins c4, c8, … c28, plus c32.
  - c0 = iCarry.
- Sum: s[i] = p[i] ^ c[i].
- Flags, all derived from the same combinational result:
  - carry = c32
  - overflow = c31 ^ c32
  - zero = (sum == 0)
  - negative = sum[31]
- Overflow and carry are independent. Both can be set at once, e.g. 0x80000000 + 0x80000000.
- No saturation. The sum always wraps modulo 2^32.
- Result must equal the behavioural reference {carry, sum} = iX + iY + iCarry for all inputs.

## Timing
- Combinational path: inputs → lookahead → sum/flags.
  - Depth is bounded by the two lookahead levels.
  - No dependence on a 32-stage ripple.
- oS and all four flags register together on each rising edge of iClk. There is no enable.
- Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- Throughput: one new operation every cycle. No handshake.
- Reset:
  - nRst low forces oS = 0, oCarry = 0, oOverflow = 0, oZero = 0, oNegative = 0 asynchronously.
  - oZero resets to 0, not 1; it reflects "no valid result yet".
  - Release is synchronous to the next rising edge. The first edge with nRst high captures the current inputs.
- Reset asserted mid-stream discards the in-flight result. Outputs stay 0 while nRst is low.

## Configuration
- CLA_INPUT_REG_EN:
  - Defined: iX, iY and iCarry are first captured in input registers (reset value 0), then fed to the lookahead logic. Latency becomes 2 cycles; throughput stays 1 per cycle.
  - Undefined: no input registers. Latency is 1 cycle as above.
  - Port list, reset values and arithmetic are identical in both builds.

## Test plan
- Small adds, one per cycle, iCarry = 0:
  - 5 + 10 → oS = 15
  - 1 + 7 → oS = 8
  - 400 + 33 → oS = 433
  - All three with oCarry = oOverflow = oZero = oNegative = 0, each appearing exactly at the configured latency.
- Signed overflow: 0x7FFFFFFF + 1 → oS = 0x80000000, oOverflow = 1, oNegative = 1, oCarry = 0, oZero = 0.
- Wrap to zero:
  - 0xFFFFFFFF + 0x00000001 → oS = 0, oCarry = 1, oZero = 1, oOverflow = 0.
  - 0xFFFFFFFF + 0 with iCarry = 1 → same result.
- Double negative: 0x80000000 + 0x80000000 → oS = 0, oCarry = 1, oOverflow = 1, oZero = 1, oNegative = 0.
- Reset mid-stream: drive 400 + 33, assert nRst low between edges → all outputs 0 immediately. After release, the next edge shows the current inputs' sum.
- Random: ≥10,000 cycles with X and Y masked to 24 bits, then full 32 bits, iCarry random → oS and flags match the behavioural reference every cycle at the configured latency.
